// File: rtl/posit_normalize_encode.sv
// Final posit datapath stage: normalise an unnormalised sum, build regime/exponent/fraction,
// round to nearest even and emit a two's-complement posit word through a 3-stage elastic pipe.
module posit_normalize_encode #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int ABITS = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_scale,
  input  logic [ABITS-1:0] in_fraction,
  input  logic             in_inf,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_posit
);
  localparam int VW = 2*NBITS - 1;       // regime + exponent + fraction + guard + sticky
  localparam int TW = ES + ABITS - 2;    // exponent, fraction, guard, sticky
  localparam int LW = $clog2(ABITS);
  localparam int RW = $clog2(NBITS + 1);
  localparam logic signed [8:0] SMAX = 9'((NBITS - 2) * (1 << ES));

  // Handshake: a word moves when valid && ready; a stage loads when its successor is
  // empty or moving on, so in_ready is high whenever any bubble exists or the output drains.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  // S1: normalise so the hidden bit sits at fraction[ABITS-2]
  logic [LW-1:0]    lzc;
  logic [ABITS-3:0] frac_n;
  logic [8:0]       scale_x, scale_n;

  always_comb begin
    scale_x = {in_scale[7], in_scale};
    lzc     = LW'(ABITS - 1);
    for (int i = 0; i < ABITS - 1; i++)
      if (in_fraction[i]) lzc = LW'(ABITS - 2 - i);
    if (in_fraction[ABITS-1]) begin
      frac_n  = {in_fraction[ABITS-2:2], in_fraction[1] | in_fraction[0]};
      scale_n = scale_x + 9'd1;
    end else begin
      frac_n  = in_fraction[ABITS-3:0] << lzc;
      scale_n = scale_x - 9'(lzc);
    end
  end

  logic             s1_sign, s1_inf, s1_zero;
  logic [8:0]       s1_scale;
  logic [ABITS-3:0] s1_frac;

  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_sign  <= in_sign;
      s1_scale <= scale_n;
      s1_frac  <= frac_n;
      s1_inf   <= in_inf;
      s1_zero  <= (in_zero || in_fraction == '0) && !in_inf;
    end
  end

  // S2: clamp scale and derive the regime run
  logic signed [8:0] sc, sc_c, k;
  logic              sat_hi, sat_lo, rpos;
  logic [RW-1:0]     rlen;

  always_comb begin
    sc     = $signed(s1_scale);
    sat_hi = sc > SMAX;
    sat_lo = sc < -SMAX;
    sc_c   = sat_hi ? SMAX : (sat_lo ? -SMAX : sc);
    k      = sc_c >>> ES;
    rpos   = !k[8];
    rlen   = rpos ? RW'(k + 9'sd1) : RW'(-k);
  end

  logic             s2_sign, s2_inf, s2_zero, s2_sat_hi, s2_sat_lo, s2_rpos;
  logic [RW-1:0]    s2_rlen;
  logic [ES-1:0]    s2_e;
  logic [ABITS-3:0] s2_fr;

  always_ff @(posedge clk) begin
    if (adv2) begin
      s2_sign   <= s1_sign;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_sat_hi <= sat_hi;
      s2_sat_lo <= sat_lo;
      s2_rpos   <= rpos;
      s2_rlen   <= rlen;
      s2_e      <= sc_c[ES-1:0];
      s2_fr     <= s1_frac;
    end
  end

  // S3: assemble, round, clamp, apply sign
  logic [VW-1:0]    reg_field, tail_field, vec;
  logic [NBITS-2:0] mag, mag_c;
  logic [NBITS-1:0] mag_r, posit;
  logic             rnd;

  always_comb begin
    reg_field  = s2_rpos ? ~({VW{1'b1}} >> s2_rlen) : ({1'b1, {(VW-1){1'b0}}} >> s2_rlen);
    tail_field = {s2_e, s2_fr, {(VW-TW){1'b0}}} >> (s2_rlen + RW'(1));
    vec        = reg_field | tail_field;
    mag        = vec[VW-1 -: NBITS-1];
    rnd        = vec[VW-NBITS] && (vec[VW-NBITS+1] || (|vec[VW-NBITS-1:0]));
    mag_r      = {1'b0, mag} + NBITS'(rnd);
    if (s2_sat_hi || mag_r[NBITS-1])
      mag_c = '1;
    else if (s2_sat_lo || mag_r[NBITS-2:0] == '0)
      mag_c = {{(NBITS-2){1'b0}}, 1'b1};
    else
      mag_c = mag_r[NBITS-2:0];
    if (s2_inf)
      posit = {1'b1, {(NBITS-1){1'b0}}};
    else if (s2_zero)
      posit = '0;
    else if (s2_sign)
      posit = -{1'b0, mag_c};
    else
      posit = {1'b0, mag_c};
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      out_posit <= '0;
    else if (adv3 && v2)
      out_posit <= posit;
  end
endmodule

// File: tb/tb_posit_normalize_encode.sv
// Directed and lightly randomised bench for posit_normalize_encode with an expected-value queue.
module tb_posit_normalize_encode;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_scale = 8'd0;
  logic [30:0] in_fraction = 31'd0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_posit;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;

  localparam logic [30:0] ONE = 31'h20000000;

  always #5 clk = ~clk;

  posit_normalize_encode dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_scale(in_scale), .in_fraction(in_fraction),
    .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // scale = 4*k, fraction 1.0: regime of k+1 ones, zero exponent and fraction
  function automatic logic [31:0] pow16(input int k, input logic s);
    logic [30:0] m;
    m = ~(31'h7FFFFFFF >> (k + 1));
    return s ? -{1'b0, m} : {1'b0, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that transferred the word.
  task automatic send(input string tag, input logic s, input logic [7:0] sc, input logic [30:0] fr,
                      input logic inf, input logic zero, input logic [31:0] exp);
    int n = 0;
    in_sign = s; in_scale = sc; in_fraction = fr; in_inf = inf; in_zero = zero;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      checks++;
      errors++;
      $error("FAIL %s_accept got in_ready=0 exp 1", tag);
      step();
    end else begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      accepted++;
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      step();
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output got %h exp none", out_posit);
      end else begin
        check(tag_q.pop_front(), out_posit, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int cnt;
    // clock/reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_posit", out_posit, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // latency with out_ready high
    send("one", 1'b0, 8'd0, ONE, 1'b0, 1'b0, 32'h40000000);
    @(negedge clk); check("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_c3", 32'(out_valid), 32'd1);
    step();

    // main function, back to back
    send("neg_1p5",    1'b1, 8'd0,  31'h30000000, 1'b0, 1'b0, 32'hBC000000);
    send("carry_2p0",  1'b0, 8'd0,  31'h40000000, 1'b0, 1'b0, 32'h48000000);
    send("half",       1'b0, 8'hFF, ONE,          1'b0, 1'b0, 32'h38000000);
    send("sixteen",    1'b0, 8'd4,  ONE,          1'b0, 1'b0, 32'h60000000);
    send("norm_lzc1",  1'b0, 8'd3,  31'h10000000, 1'b0, 1'b0, 32'h50000000);
    send("norm_lzc27", 1'b0, 8'd27, 31'h00000004, 1'b0, 1'b0, 32'h40000000);
    send("norm_lzc29", 1'b0, 8'd29, 31'h00000001, 1'b0, 1'b0, 32'h40000000);
    send("neg_one",    1'b1, 8'd0,  ONE,          1'b0, 1'b0, 32'hC0000000);
    send("sat_hi",     1'b0, 8'h7F, ONE,          1'b0, 1'b0, 32'h7FFFFFFF);
    send("sat_lo",     1'b0, 8'h80, ONE,          1'b0, 1'b0, 32'h00000001);
    send("sat_lo_neg", 1'b1, 8'h80, ONE,          1'b0, 1'b0, 32'hFFFFFFFF);
    send("scale_120",  1'b0, 8'd120, ONE,         1'b0, 1'b0, 32'h7FFFFFFF);
    send("scale_119",  1'b0, 8'd119, ONE,         1'b0, 1'b0, 32'h7FFFFFFF);
    send("scale_117",  1'b0, 8'd117, ONE,         1'b0, 1'b0, 32'h7FFFFFFE);
    send("scale_m120", 1'b0, 8'h88, ONE,          1'b0, 1'b0, 32'h00000001);
    send("scale_m121", 1'b0, 8'h87, ONE,          1'b0, 1'b0, 32'h00000001);
    send("scale_m117", 1'b0, 8'h8B, ONE,          1'b0, 1'b0, 32'h00000002);
    send("zero_flag",  1'b1, 8'd0,  ONE,          1'b0, 1'b1, 32'h00000000);
    send("inf_flag",   1'b1, 8'd0,  ONE,          1'b1, 1'b0, 32'h80000000);
    send("inf_zero",   1'b0, 8'd0,  ONE,          1'b1, 1'b1, 32'h80000000);
    send("frac_lost",  1'b1, 8'd5,  31'h00000000, 1'b0, 1'b0, 32'h00000000);
    send("rne_tie",    1'b0, 8'd0,  31'h20000002, 1'b0, 1'b0, 32'h40000000);
    send("rne_sticky", 1'b0, 8'd0,  31'h20000003, 1'b0, 1'b0, 32'h40000001);
    send("rne_tie_odd",1'b0, 8'd0,  31'h20000006, 1'b0, 1'b0, 32'h40000002);
    send("carry_stk",  1'b0, 8'd0,  31'h40000006, 1'b0, 1'b0, 32'h48000001);
    for (int i = 0; i < 8; i++) begin
      logic s;
      int   k;
      s = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 7);
      send($sformatf("rand%0d", i), s, 8'(4 * k), ONE, 1'b0, 1'b0, pow16(k, s));
    end
    drain("drain_main");

    // backpressure: five offered, three fit
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send($sformatf("bp%0d", i), 1'b0, 8'(4 * i), ONE, 1'b0, 1'b0, pow16(i, 1'b0));
      end
    join_none
    repeat (5) @(negedge clk);
    held = out_posit;
    repeat (3) @(negedge clk);
    check("bp_accepted", 32'(accepted), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold", out_posit, held);
    check("bp_head", out_posit, 32'h40000000);
    step();
    out_ready = 1'b1;
    drain("drain_bp");
    check("bp_all_accepted", 32'(accepted), 32'd5);

    // reset with three words in flight
    out_ready = 1'b0;
    send("rst_a", 1'b0, 8'd0, ONE, 1'b0, 1'b0, 32'h40000000);
    send("rst_b", 1'b0, 8'd4, ONE, 1'b0, 1'b0, 32'h60000000);
    send("rst_c", 1'b1, 8'd0, ONE, 1'b0, 1'b0, 32'hC0000000);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_mid_no_output", 32'(cnt), 32'd0);
    step();
    send("post_rst", 1'b0, 8'hFF, ONE, 1'b0, 1'b0, 32'h38000000);
    drain("drain_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
